// File: rtl/seven_segment_multi_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | seven_segment_multi_if -- control and display bundle for the counter.     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface seven_segment_multi_if #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE_W = 24
);
   logic [PRESCALE_W-1:0] compare_in;
   logic                  update_compare;
   logic                  enable;
   logic                  count_down;
   logic                  clear;
   logic [6:0]            led_out;
   logic [NUM_DIGITS-1:0] digit_sel;
   logic                  rollover;

   modport master (
      output compare_in, update_compare, enable, count_down, clear,
      input  led_out, digit_sel, rollover
   );

   modport slave (
      input  compare_in, update_compare, enable, count_down, clear,
      output led_out, digit_sel, rollover
   );
endinterface
`default_nettype wire

// File: rtl/seven_segment_multi.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | seven_segment_multi -- prescaled BCD up/down counter with scanned display. |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module seven_segment_multi #(
   parameter int NUM_DIGITS     = 4,
   parameter int PRESCALE_W     = 24,
   parameter int MAX_COUNT      = 16_000_000,
   parameter int MUX_DIV        = 16_000,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   seven_segment_multi_if.slave       bus
);
   localparam int SCAN_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [6:0] SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   logic [PRESCALE_W-1:0] compare_q;
   logic [PRESCALE_W-1:0] presc_q;
   logic [3:0]            digits_q [NUM_DIGITS];
   logic [3:0]            digits_d [NUM_DIGITS];
   logic [SCAN_W-1:0]     scan_cnt_q;
   logic [IDX_W-1:0]      scan_idx_q;
   logic [6:0]            led_out_q;
   logic [NUM_DIGITS-1:0] digit_sel_q;
   logic                  rollover_q;

   logic [PRESCALE_W-1:0] presc_last;
   logic                  tick;
   logic                  carry;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   // A compare of zero is treated as one, so the last prescaler value is 0.
   assign presc_last = (compare_q == '0) ? '0 : compare_q - PRESCALE_W'(1);
   assign tick       = bus.enable && (presc_q == presc_last);

   // Ripple carry/borrow across all digits; carry out of the top is a wrap.
   always_comb begin
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digits_d[i] = digits_q[i];
         if (carry) begin
            if (!bus.count_down) begin
               if (digits_q[i] >= 4'd9) begin
                  digits_d[i] = 4'd0;
               end else begin
                  digits_d[i] = digits_q[i] + 4'd1;
                  carry       = 1'b0;
               end
            end else begin
               if (digits_q[i] == 4'd0 || digits_q[i] > 4'd9) begin
                  digits_d[i] = 4'd9;
               end else begin
                  digits_d[i] = digits_q[i] - 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         compare_q   <= PRESCALE_W'(MAX_COUNT);
         presc_q     <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= 4'd0;
         scan_cnt_q  <= '0;
         scan_idx_q  <= '0;
         digit_sel_q <= NUM_DIGITS'(1);
         led_out_q   <= seg_decode(4'd0) ^ SEG_XOR;
         rollover_q  <= 1'b0;
      end else begin
         digit_sel_q <= NUM_DIGITS'(1) << scan_idx_q;
         led_out_q   <= seg_decode(digits_q[scan_idx_q]) ^ SEG_XOR;
         rollover_q  <= 1'b0;

         if (scan_cnt_q == SCAN_W'(MUX_DIV - 1)) begin
            scan_cnt_q <= '0;
            scan_idx_q <= (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
         end else begin
            scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
         end

         if (bus.update_compare) begin
            compare_q <= bus.compare_in;
            presc_q   <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= 4'd0;
         end else if (bus.clear) begin
            presc_q   <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= 4'd0;
         end else if (tick) begin
            presc_q    <= '0;
            digits_q   <= digits_d;
            rollover_q <= carry;
         end else if (bus.enable) begin
            presc_q    <= presc_q + PRESCALE_W'(1);
         end
      end
   end

   assign bus.led_out   = led_out_q;
   assign bus.digit_sel = digit_sel_q;
   assign bus.rollover  = rollover_q;
endmodule
`default_nettype wire

// File: doc/seven_segment_multi.md
SEVEN_SEGMENT_MULTI -- requirements
Module: seven_segment_multi

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD display digits (1..8).
REQ-002 The block SHALL have parameter PRESCALE_W, default 24, giving the prescaler and compare width.
REQ-003 The block SHALL have parameter MAX_COUNT, default 16_000_000, giving the compare value after reset (one tick per second at 16 MHz).
REQ-004 The block SHALL have parameter MUX_DIV, default 16_000, giving the clocks per scan slot (1 ms at 16 MHz).
REQ-005 The block SHALL have parameter SEG_ACTIVE_LOW, default 0; when 1, led_out is inverted.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 compare_in  input  PRESCALE_W  new prescaler compare value.
REQ-009 update_compare  input  1  loads compare_in and clears the count.
REQ-010 enable  input  1  high allows the prescaler to run; low freezes prescaler and digits.
REQ-011 count_down  input  1  0 counts up, 1 counts down; sampled on each tick.
REQ-012 clear  input  1  zeroes the digits and prescaler, keeping compare.
REQ-013 led_out  output  7  registered segments of the scanned digit; bit0=a(top), bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g(middle).
REQ-014 digit_sel  output  NUM_DIGITS  registered, one-hot, active-high digit enable; bit i selects digit i (digit 0 is the least significant).
REQ-015 rollover  output  1  registered pulse, high for one cycle when the whole counter wraps.

Function
REQ-016 Command priority per cycle SHALL be: reset > update_compare > clear > tick.
REQ-017 The effective compare SHALL be max(compare, 1); compare=0 behaves as 1, giving a tick every enabled cycle.
REQ-018 The prescaler SHALL count 0..eff-1 while enable=1, assert tick in the cycle it equals eff-1, and wrap to 0.
REQ-019 When enable=0, the prescaler SHALL hold and no tick SHALL occur.
REQ-020 On update_compare, compare <= compare_in, and prescaler and all digits SHALL be set to 0 in the same edge; no tick occurs that cycle.
REQ-021 On clear, the prescaler and all digits SHALL be set to 0; compare SHALL be unchanged; no tick occurs that cycle.
REQ-022 On an up-tick, digit 0 SHALL increment; a digit at 9 SHALL become 0 and carry into the next digit (ripple within the same edge).
REQ-023 On a down-tick, digit 0 SHALL decrement; a digit at 0 SHALL become 9 and borrow from the next digit.
REQ-024 An up-tick from all-9 SHALL give all-0 and a down-tick from all-0 SHALL give all-9; rollover SHALL be 1 in the following cycle only.
REQ-025 The digits SHALL only ever hold values 0..9.
REQ-026 The scan counter SHALL run every cycle regardless of enable, counting 0..MUX_DIV-1; at MUX_DIV-1 the scan index SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-027 Each cycle, digit_sel SHALL be registered as onehot(scan index), and led_out as decode(digit[scan index]) using the current digit value. This gives one cycle of latency from a digit or index change to the outputs.
REQ-028 Decode table (bits g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-029 With MUX_DIV=1, the scan index SHALL advance every cycle.
REQ-030 With NUM_DIGITS=1, digit_sel SHALL be constant 1.

Reset
REQ-031 When reset=1 at an edge, the following SHALL be set: compare=MAX_COUNT, prescaler=0, all digits=0, scan counter=0, scan index=0.
REQ-032 At the same edge, the outputs SHALL be set to digit_sel=1, led_out=0111111 (inverted if SEG_ACTIVE_LOW), rollover=0.
REQ-033 Reset asserted mid-count or mid-scan SHALL fully override every other input in that cycle.

Verification
REQ-034 Bench config NUM_DIGITS=2, MUX_DIV=2: reset, then update_compare with compare_in=4, enable=1 -> digits advance once every 4 cycles: 00, 01, ..., 09, 10.
REQ-035 Preload 99, up-tick -> digits 00, rollover high for exactly 1 cycle; count_down=1 from 00 -> 99 with a rollover pulse.
REQ-036 compare_in=0 with enable=1 -> digits increment every cycle; enable=0 for 5 cycles -> digits and prescaler frozen.
REQ-037 update_compare and clear asserted together while counting -> compare loaded, digits 00, no tick that cycle; clear alone -> digits 00 with compare retained.
REQ-038 Scan check, digits=37 -> digit_sel alternates 01/10 every 2 cycles, with led_out 1111000... no: led_out=0000111 (7) while digit_sel=01 and 1001111 (3) while digit_sel=10. SEG_ACTIVE_LOW=1 -> both patterns inverted.
REQ-039 Reset asserted mid-count with digits=45 -> next cycle digits 00, digit_sel=01, led_out=0111111, rollover=0, compare=MAX_COUNT.
